// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes that the
// controller reacts to, the controller state encoding and the NOP word.
package pipe_ctrl_pkg;

   localparam logic [5:0]  OP_LDR  = 6'h10;
   localparam logic [5:0]  OP_MUL  = 6'h08;
   localparam logic [5:0]  OP_HALT = 6'h3F;
   localparam logic [25:0] NOP     = 26'h0;

   typedef enum logic [2:0] {
      RUN        = 3'd0,
      LOAD_STALL = 3'd1,
      MUL_WAIT   = 3'd2,
      FLUSH      = 3'd3,
      HALT       = 3'd4
   } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load
// in EX is about to write. r0 is hardwired, so it never creates a hazard.
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   output logic             hazard
);

   // Pure compare, no state
   always_comb begin
      hazard = ex_is_load && (ex_rd != '0) && ((ex_rd == id_rn) || (ex_rd == id_rm));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: PC enable / next-PC, IF/ID hold and flush, ID/EX
// bubble and EX hold for load-use stalls, taken branches, multicycle MUL and
// HALT. Optional stall-cycle counter behind PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int PC_W         = 16,
   parameter int REG_W        = 5,
   parameter int OP_W         = 6,
   parameter int MUL_CYCLES   = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OP_W-1:0]  id_opcode,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_branch_taken,
   input  logic [PC_W-1:0]  ex_branch_target,
   input  logic [PC_W-1:0]  pc_count,
   output logic             pc_en,
   output logic [PC_W-1:0]  new_pc,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_hold,
   output logic             halted
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   localparam logic [7:0] MUL_LOAD   = 8'(MUL_CYCLES - 1);
   localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       hazard;

   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .ex_is_load (ex_is_load),
      .ex_rd      (ex_rd),
      .id_rn      (id_rn),
      .id_rm      (id_rm),
      .hazard     (hazard)
   );

   // Outputs and next state from current state and inputs; reset forces the
   // quiescent values so the pipe loads NOPs while rst is low
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      new_pc       = pc_count + PC_W'(1);
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_hold      = 1'b0;
      halted       = 1'b0;
      state_nxt    = state;
      cnt_nxt      = cnt;
      case (state)
         RUN: begin
            if (ex_branch_taken) begin
               new_pc       = ex_branch_target;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_nxt = FLUSH;
                  cnt_nxt   = FLUSH_LOAD;
               end
            end else if (hazard) begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_bubble = 1'b1;
               state_nxt    = LOAD_STALL;
            end else if (id_opcode == OP_MUL) begin
               state_nxt = MUL_WAIT;
               cnt_nxt   = MUL_LOAD;
            end else if (id_opcode == OP_HALT) begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_bubble = 1'b1;
               state_nxt    = HALT;
            end
         end
         // One cycle of plain advance after the stall bubble
         LOAD_STALL: state_nxt = RUN;
         MUL_WAIT: begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            ex_hold  = 1'b1;
            cnt_nxt  = cnt - 8'd1;
            if (cnt == 8'd1) state_nxt = RUN;
         end
         FLUSH: begin
            if_id_flush = 1'b1;
            if (ex_branch_taken) begin
               new_pc       = ex_branch_target;
               id_ex_bubble = 1'b1;
               cnt_nxt      = FLUSH_LOAD;
            end else begin
               cnt_nxt = cnt - 8'd1;
               if (cnt == 8'd1) state_nxt = RUN;
            end
         end
         HALT: begin
            halted       = 1'b1;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
         end
         default: state_nxt = RUN;
      endcase
      if (!rst) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         new_pc       = '0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         ex_hold      = 1'b0;
         halted       = 1'b0;
      end
   end

   // State and down-counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   // Saturating count of cycles the PC is frozen by a hazard (HALT excluded)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_cnt <= 16'd0;
      else if (!pc_en && !halted && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the 26-bit-instruction, 16-bit-PC core.
- Sequences the pc counter, the Pipeline_IF_ID register and the ID/EX register.
- Generates PC enable and next-PC, IF/ID hold and flush, ID/EX bubble and EX hold.
- Resolves load-use hazards, taken branches, multicycle MUL and HALT.
- Sits between decoInst (ID-stage fields), the EX stage and the fetch logic.

Parameters:
- PC_W, 16, PC / address width.
- REG_W, 5, register index width.
- OP_W, 6, opcode width.
- MUL_CYCLES, 4, total EX occupancy of a MUL (min 2).
- FLUSH_CYCLES, 2, wrong-path fetch slots to squash after a taken branch (min 1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_opcode  in  OP_W  opcode of instruction in ID
- id_rn  in  REG_W  source reg A in ID
- id_rm  in  REG_W  source reg B in ID
- ex_rd  in  REG_W  destination reg of instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch this cycle
- ex_branch_target  in  PC_W  branch target
- pc_count  in  PC_W  current PC
- pc_en  out  1  pc register load enable
- new_pc  out  PC_W  next PC value
- if_id_en  out  1  IF/ID register capture enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_bubble  out  1  ID/EX loads NOP
- ex_hold  out  1  EX stage holds its current instruction
- halted  out  1  core halted

Behaviour:
- FSM states: RUN, LOAD_STALL, MUL_WAIT, FLUSH, HALT. Register state plus an 8-bit down-counter cnt.
- Outputs are combinational from state and inputs.
- During reset (rst=0):
  - state=RUN, cnt=0.
  - pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, ex_hold=0, halted=0, new_pc=0.
- Default in RUN with no event: pc_en=1, if_id_en=1, new_pc=pc_count+1 (mod 2^PC_W, so 16'hFFFF wraps to 0), all others 0.
- RUN event priority, highest first:
  1. ex_branch_taken:
     - new_pc=ex_branch_target, pc_en=1, if_id_flush=1, id_ex_bubble=1.
     - If FLUSH_CYCLES>1: cnt<=FLUSH_CYCLES-1, go to FLUSH. Otherwise stay in RUN.
  2. Load-use: ex_is_load and ex_rd!=0 and (ex_rd==id_rn or ex_rd==id_rm).
     - pc_en=0, if_id_en=0, id_ex_bubble=1; go to LOAD_STALL.
  3. id_opcode==OP_MUL:
     - Normal advance this cycle (MUL issues to EX); cnt<=MUL_CYCLES-1; go to MUL_WAIT.
  4. id_opcode==OP_HALT:
     - pc_en=0, if_id_en=0, id_ex_bubble=1; go to HALT.
- LOAD_STALL: exactly 1 cycle with RUN-default outputs (re-evaluate nothing); then RUN.
- MUL_WAIT:
  - Outputs: pc_en=0, if_id_en=0, ex_hold=1, id_ex_bubble=0.
  - cnt decrements; leave to RUN in the cycle cnt==1.
  - ex_branch_taken is ignored.
- FLUSH:
  - Outputs: pc_en=1, new_pc=pc_count+1, if_id_flush=1.
  - cnt decrements; leave to RUN when cnt==1.
  - A new ex_branch_taken here restarts the flush with the new target and cnt reloaded.
- HALT:
  - Outputs: halted=1, pc_en=0, if_id_en=0, id_ex_bubble=1.
  - Terminal until rst; all inputs ignored.
- A reset asserted mid-stall or mid-flush aborts immediately to the reset values.
- r0 never creates a load-use hazard.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined:
  - Adds output stall_cnt [15:0]: counts cycles with pc_en=0 while not halted.
  - Saturates at 16'hFFFF; cleared by rst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - Opcode constants OP_LDR=6'h10, OP_MUL=6'h08, OP_HALT=6'h3F.
  - State enum typedef.
  - NOP encoding 26'h0.
- One natural sub-module, hazard_detect: combinational load-use comparator (ex_is_load, ex_rd, id_rn, id_rm -> hazard).

Test Plan:
- Straight-line fetch:
  - Stimulus: release rst at pc_count=0; no events.
  - Expected: new_pc=1,2,3…; pc_count=16'hFFFF gives new_pc=0.
- Load-use:
  - Stimulus: ex_is_load=1, ex_rd=3, id_rm=3.
  - Expected: one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1, then normal flow.
  - Repeat with ex_rd=0: expect no stall.
- Taken branch:
  - Stimulus: ex_branch_taken=1, target=16'h0040, FLUSH_CYCLES=2.
  - Expected: new_pc=0040; if_id_flush=1 for 2 cycles; id_ex_bubble=1 for 1 cycle.
- MUL:
  - Stimulus: id_opcode=OP_MUL, MUL_CYCLES=4.
  - Expected: issue cycle normal, then ex_hold=1 and pc_en=0 for 3 cycles, then RUN.
- HALT then reset:
  - Stimulus: id_opcode=OP_HALT.
  - Expected: halted=1 and pc_en=0 indefinitely, ignoring branches.
  - Drop rst mid-HALT: expect reset values, then RUN after release.
- Perf counter (PIPE_HAZARD_PERF_EN defined):
  - Stimulus: one load stall plus one MUL.
  - Expected: stall_cnt=4.
